xgriscv_fetch_queue: RTL and testbench

//  Instruction fetch front-end placed between instruction memory and the pipeline's IF/ID registers.

---
 rtl/xgriscv_fetch_queue.sv | 161 ++++++++++++++++
 tb/tb_xgriscv_fetch_queue.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgriscv_fetch_queue.sv
// -----------------------------------------------------------------------------
// xgriscv_fetch_queue
//
// Instruction fetch front-end that sits between instruction memory and the
// IF/ID pipeline registers. It owns the fetch PC and issues sequential
// word-aligned requests to a variable-latency imem. Returned instructions are
// buffered, together with their PCs, in a DEPTH-entry FIFO. The FIFO head is
// presented to the pipeline as instrF / pcF / pcplus4F.
//
// When EX redirects fetch (a taken branch or jump), the FIFO is flushed. Every
// request still outstanding at that moment is re-labelled stale, and its
// response is later discarded on arrival.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   imem_req_valid/ready/addr  request channel (address = fetch PC)
//   imem_rsp_valid/data        in-order response channel
//   redirect, redirect_pc      taken branch/jump from EX (target bits [1:0] ignored)
//   deq_ready                  pipeline consumes the head this cycle
//   instr_valid, instrF,       FIFO head; a NOP / 0 / 0 is presented
//   pcF, pcplus4F              while the FIFO is empty
// -----------------------------------------------------------------------------
module xgriscv_fetch_queue #(
  parameter int unsigned           ADDR_SIZE  = 32,
  parameter int unsigned           INSTR_SIZE = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_SIZE-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_SIZE-1:0]  imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INSTR_SIZE-1:0] imem_rsp_data,
  input  logic                  redirect,
  input  logic [ADDR_SIZE-1:0]  redirect_pc,
  input  logic                  deq_ready,
  output logic                  instr_valid,
  output logic [INSTR_SIZE-1:0] instrF,
  output logic [ADDR_SIZE-1:0]  pcF,
  output logic [ADDR_SIZE-1:0]  pcplus4F
);

  localparam int unsigned           PTR_W   = $clog2(DEPTH);
  localparam int unsigned           CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]        DEPTH_W = (CNT_W + 1)'(DEPTH);
  localparam logic [INSTR_SIZE-1:0] NOP     = INSTR_SIZE'(32'h0000_0013);

  logic [ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     inflight_q, inflight_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;

  logic [INSTR_SIZE-1:0] fifo_instr_q [DEPTH];
  logic [ADDR_SIZE-1:0]  fifo_pc_q    [DEPTH];

  logic [CNT_W:0]       occ_sum;
  logic [CNT_W:0]       out_sum;
  logic                 rsp_live;
  logic                 rsp_drop;
  logic                 push;
  logic                 pop;
  logic                 req_fire;
  logic [ADDR_SIZE-1:0] rsp_pc;

  // Live requests were issued back to back, ending just before fetch_pc. The
  // oldest live request therefore sits inflight words behind fetch_pc. Stale
  // requests are always older than live ones, so a response that arrives
  // while drop_cnt is zero belongs to this address.
  assign rsp_pc = fetch_pc_q - (ADDR_SIZE'(inflight_q) << 2);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    occ_sum  = {1'b0, count_q} + {1'b0, inflight_q};
    out_sum  = {1'b0, inflight_q} + {1'b0, drop_cnt_q};

    // Credits: the FIFO must have room for every live request, and the
    // response tracker must have room for stale plus live requests.
    imem_req_valid = !reset && !redirect && (occ_sum < DEPTH_W) && (out_sum < DEPTH_W);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error. It is ignored.
    rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);
    rsp_live = imem_rsp_valid && (drop_cnt_q == '0) && (inflight_q != '0);

    instr_valid = !reset && (count_q != '0);
    push        = rsp_live && !redirect;
    pop         = deq_ready && instr_valid && !redirect;

    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (redirect) begin
      // Every request still outstanding turns stale. A response arriving in
      // this same cycle is already consumed, so it is not counted.
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      inflight_d = '0;
      drop_cnt_d = drop_cnt_q + inflight_q - CNT_W'(rsp_live || rsp_drop);
      fetch_pc_d = redirect_pc & ~ADDR_SIZE'(3);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + ADDR_SIZE'(4);
      end
      inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_live);
      drop_cnt_d = drop_cnt_q - CNT_W'(rsp_drop);
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
      head_d     = head_q + PTR_W'(pop);
      tail_d     = tail_q + PTR_W'(push);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // NOTE: FIFO storage has no reset; count_q decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_instr_q[tail_q] <= imem_rsp_data;
      fifo_pc_q[tail_q]    <= rsp_pc;
    end
  end

  // The head outputs are driven only from registers, with no path from the imem inputs.
  always_comb begin
    instrF   = NOP;
    pcF      = '0;
    pcplus4F = '0;
    if (instr_valid) begin
      instrF   = fifo_instr_q[head_q];
      pcF      = fifo_pc_q[head_q];
      pcplus4F = fifo_pc_q[head_q] + ADDR_SIZE'(4);
    end
  end

endmodule

// File: tb/tb_xgriscv_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_xgriscv_fetch_queue
//
// Bench for xgriscv_fetch_queue. An in-order imem model with variable latency
// answers accepted requests. A transaction-level reference model uses queues:
//   - outstanding requests, each tagged stale or live;
//   - buffered {pc, instr} entries;
//   - the next fetch address.
// From these it predicts every output on every cycle. Directed phases pin the
// model with literal values; a long randomized phase follows.
// -----------------------------------------------------------------------------
module tb_xgriscv_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        instr_valid;
  logic [31:0] instrF;
  logic [31:0] pcF;
  logic [31:0] pcplus4F;

  always #5 clk = ~clk;

  xgriscv_fetch_queue #(
    .ADDR_SIZE (32),
    .INSTR_SIZE(32),
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .deq_ready     (deq_ready),
    .instr_valid   (instr_valid),
    .instrF        (instrF),
    .pcF           (pcF),
    .pcplus4F      (pcplus4F)
  );

  typedef struct { logic [31:0] pc; bit stale; }          req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int due; }          mem_t;

  req_t        out_q[$];   // outstanding requests, oldest first
  ent_t        fifo_m[$];  // buffered instructions, head first
  mem_t        mem_q[$];   // imem pipeline, oldest first
  logic [31:0] m_pc;

  int          cyc, n_vec, n_err;
  int          pct_redirect, pct_reset_pm, pct_deq, pct_ready, lat_min, lat_max;
  bit          rst_cmd, redir_cmd;
  logic [31:0] redir_tgt;

  logic        s_req_valid, s_iv, s_dut_fire;
  logic [31:0] s_req_addr, s_instr, s_pc, s_pc4;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // One clock cycle. On entry we sit just after a rising edge. Inputs are
  // driven, the outputs are compared with the model on the falling edge, the
  // model is advanced, and the task returns just after the next rising edge.
  task automatic run_cycle();
    logic        e_rv, e_iv, do_pop;
    logic [31:0] e_instr, e_pc, e_pc4;
    int          live;
    req_t        r;
    ent_t        e;
    mem_t        m;

    reset          = rst_cmd || ($urandom_range(999) < pct_reset_pm);
    redirect       = !reset && (redir_cmd || ($urandom_range(99) < pct_redirect));
    redirect_pc    = redir_cmd ? redir_tgt : $urandom;
    deq_ready      = $urandom_range(99) < pct_deq;
    imem_req_ready = $urandom_range(99) < pct_ready;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q[0].addr);
    end

    live = 0;
    foreach (out_q[i]) if (!out_q[i].stale) live++;
    e_rv    = !reset && !redirect && (fifo_m.size() + live < DEPTH) && (out_q.size() < DEPTH);
    e_iv    = !reset && (fifo_m.size() > 0);
    e_instr = e_iv ? fifo_m[0].instr : NOP;
    e_pc    = e_iv ? fifo_m[0].pc : 32'h0;
    e_pc4   = e_iv ? fifo_m[0].pc + 32'd4 : 32'h0;

    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_iv        = instr_valid;
    s_instr     = instrF;
    s_pc        = pcF;
    s_pc4       = pcplus4F;
    s_dut_fire  = imem_req_valid && imem_req_ready;

    checkb("req_valid", s_req_valid, e_rv);
    if (e_rv) check("req_addr", s_req_addr, m_pc);
    checkb("instr_valid", s_iv, e_iv);
    check("instrF", s_instr, e_instr);
    check("pcF", s_pc, e_pc);
    check("pcplus4F", s_pc4, e_pc4);

    if (reset) begin
      out_q.delete();
      fifo_m.delete();
      mem_q.delete();
      m_pc = RESET_PC;
    end else begin
      do_pop = !redirect && deq_ready && (fifo_m.size() > 0);
      if (imem_rsp_valid) m = mem_q.pop_front();
      if (redirect) begin
        fifo_m.delete();
        if (imem_rsp_valid && out_q.size() > 0) r = out_q.pop_front();
        foreach (out_q[i]) out_q[i].stale = 1'b1;
        m_pc = redirect_pc & ~32'd3;
      end else begin
        if (do_pop) e = fifo_m.pop_front();
        if (imem_rsp_valid && out_q.size() > 0) begin
          r = out_q.pop_front();
          if (!r.stale) fifo_m.push_back('{pc: r.pc, instr: imem_rsp_data});
        end
        if (e_rv && imem_req_ready) begin
          out_q.push_back('{pc: m_pc, stale: 1'b0});
          mem_q.push_back('{addr: m_pc, due: cyc + int'($urandom_range(lat_max, lat_min))});
          m_pc = m_pc + 32'd4;
        end
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Stop issuing until every outstanding response has returned.
  task automatic drain();
    pct_ready = 0;
    repeat (7) run_cycle();
    pct_ready = 100;
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redir_cmd = 1'b1;
    redir_tgt = tgt;
    run_cycle();
    redir_cmd = 1'b0;
  endtask

  int n_fire;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    pct_redirect = 0; pct_reset_pm = 0; pct_deq = 100; pct_ready = 100;
    lat_min = 1; lat_max = 1;
    rst_cmd = 1'b1; redir_cmd = 1'b0; redir_tgt = '0;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    m_pc = RESET_PC;
    @(posedge clk);
    #1;

    // Reset, then a 1-cycle imem stream that starts near the address wrap.
    repeat (2) run_cycle();
    checkb("rst_req_valid", s_req_valid, 1'b0);
    checkb("rst_instr_valid", s_iv, 1'b0);
    check("rst_instrF", s_instr, NOP);
    check("rst_pcplus4F", s_pc4, 32'h0);
    rst_cmd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      run_cycle();
      case (k)
        0: begin
          check("t1_addr0", s_req_addr, 32'hFFFF_FFF8);
          check("t1_nop", s_instr, NOP);
        end
        1: check("t1_addr1", s_req_addr, 32'hFFFF_FFFC);
        2: begin
          check("t1_addr2", s_req_addr, 32'h0000_0000);
          check("t1_pc0", s_pc, 32'hFFFF_FFF8);
        end
        default: begin
          check("t1_pc1", s_pc, 32'hFFFF_FFFC);
          check("t1_pc4_wrap", s_pc4, 32'h0000_0000);
        end
      endcase
    end

    // Stall the pipeline: exactly DEPTH requests are accepted, then issue stops.
    redirect_to(32'h0);
    pct_deq = 0;
    n_fire  = 0;
    repeat (10) begin
      run_cycle();
      if (s_dut_fire) n_fire++;
    end
    check("t2_accepted", n_fire, 32'd4);
    checkb("t2_req_stopped", s_req_valid, 1'b0);
    check("t2_head", s_pc, 32'h0);
    pct_deq = 100;
    for (int k = 0; k < 5; k++) begin
      run_cycle();
      check("t2_pop_pc", s_pc, 32'(k * 4));
      if (k == 1) check("t2_resume_addr", s_req_addr, 32'h10);
    end

    // 3-cycle imem: redirect with two requests in flight.
    drain();
    lat_min = 3; lat_max = 3;
    redirect_to(32'h0);
    run_cycle();
    run_cycle();
    redirect_to(32'h107);
    for (int k = 0; k < 5; k++) begin
      run_cycle();
      if (k == 0) check("t3_addr", s_req_addr, 32'h104);
      if (k == 2) checkb("t3_empty", s_iv, 1'b0);
      if (k == 4) begin
        check("t3_pc", s_pc, 32'h104);
        check("t3_instr", s_instr, instr_of(32'h104));
      end
    end

    // Redirect together with a response and deq_ready, using a 2-cycle imem.
    drain();
    lat_min = 2; lat_max = 2;
    redirect_to(32'h300);
    repeat (3) run_cycle();
    redirect_to(32'h400);
    check("t4_head_before", s_pc, 32'h300);
    for (int k = 0; k < 4; k++) begin
      run_cycle();
      if (k == 0) begin
        checkb("t4_flushed", s_iv, 1'b0);
        check("t4_addr", s_req_addr, 32'h400);
      end
      if (k == 3) check("t4_pc", s_pc, 32'h400);
    end

    // Back-pressure from imem, then a redirect withdraws the pending request.
    drain();
    pct_ready = 0;
    redirect_to(32'h500);
    for (int k = 0; k < 5; k++) begin
      run_cycle();
      checkb("t5_hold_valid", s_req_valid, 1'b1);
      check("t5_hold_addr", s_req_addr, 32'h500);
    end
    pct_ready = 100;
    run_cycle();
    checkb("t5_accepted", s_dut_fire, 1'b1);
    pct_ready = 0;
    run_cycle();
    check("t5_next_addr", s_req_addr, 32'h504);
    redirect_to(32'h600);
    checkb("t5_withdrawn", s_req_valid, 1'b0);
    run_cycle();
    check("t5_new_addr", s_req_addr, 32'h600);

    // Reset in the middle of a stream.
    pct_ready = 100; lat_min = 1; lat_max = 3;
    repeat (8) run_cycle();
    rst_cmd = 1'b1;
    run_cycle();
    rst_cmd = 1'b0;
    run_cycle();
    checkb("t6_iv_after_reset", s_iv, 1'b0);
    check("t6_refetch", s_req_addr, RESET_PC);

    // Randomized traffic.
    for (int blk = 0; blk < 20; blk++) begin
      pct_deq      = $urandom_range(100);
      pct_ready    = $urandom_range(100, 10);
      pct_redirect = $urandom_range(10);
      pct_reset_pm = $urandom_range(4);
      lat_min      = 1;
      lat_max      = $urandom_range(5, 1);
      repeat (200) run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
